// File: rtl/fault_cam_pkg.sv
// Shared state codes, descriptor values and helpers for the fault_cam_ra redundancy-analysis CAM.
// The optional column-group fold (FAULT_CAM_COL_GROUP_EN) uses msb_idx8 from here.
package fault_cam_pkg;

    localparam logic [1:0] ST_COLLECT = 2'd0;
    localparam logic [1:0] ST_FAIL    = 2'd1;
    localparam logic [1:0] ST_DONE    = 2'd2;

    localparam logic DSC_ROW = 1'b0;
    localparam logic DSC_COL = 1'b1;

    // Index of the highest set bit; 0 when no bit is set so the fold is a no-op.
    function automatic logic [2:0] msb_idx8(input logic [7:0] flags);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (flags[i]) idx = 3'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/fault_cam_match.sv
// Parallel comparator of one fault against all pivots and reconstructed non-pivots.
// Lowest matching index wins; a row hit always takes priority over a column hit.
module fault_cam_match
    import fault_cam_pkg::*;
#(
    parameter int ROW_W   = 10,
    parameter int COL_W   = 10,
    parameter int BNK_W   = 2,
    parameter int PCAM_N  = 8,
    parameter int NPCAM_N = 30,
    parameter int IDX_W   = 3,
    parameter int AW      = 10
) (
    input  logic [ROW_W-1:0]                in_row,
    input  logic [COL_W-1:0]                in_col,
    input  logic [BNK_W-1:0]                in_bnk,
    input  logic [PCAM_N-1:0]               p_valid,
    input  logic [PCAM_N-1:0][ROW_W-1:0]    p_row,
    input  logic [PCAM_N-1:0][COL_W-1:0]    p_col,
    input  logic [PCAM_N-1:0][BNK_W-1:0]    p_bnk,
    input  logic [NPCAM_N-1:0]              np_valid,
    input  logic [NPCAM_N-1:0]              np_dsc,
    input  logic [NPCAM_N-1:0][IDX_W-1:0]   np_ptr,
    input  logic [NPCAM_N-1:0][AW-1:0]      np_addr,
    output logic                            hit_row,
    output logic                            hit_col,
    output logic [IDX_W-1:0]                hit_idx,
    output logic                            dup
);

    logic [PCAM_N-1:0]  row_m;
    logic [PCAM_N-1:0]  col_m;
    logic [PCAM_N-1:0]  p_dup;
    logic [NPCAM_N-1:0] np_dup;
    logic [IDX_W-1:0]   row_idx;
    logic [IDX_W-1:0]   col_idx;

    always_comb begin
        for (int i = 0; i < PCAM_N; i++) begin
            row_m[i] = p_valid[i] && (p_row[i] == in_row) && (p_bnk[i] == in_bnk);
            col_m[i] = p_valid[i] && (p_col[i] == in_col) && (p_bnk[i] == in_bnk);
            p_dup[i] = row_m[i] && (p_col[i] == in_col);
        end
        // A non-pivot only stores the differing coordinate; the rest comes from its pivot.
        for (int j = 0; j < NPCAM_N; j++) begin
            np_dup[j] = 1'b0;
            if (np_valid[j]) begin
                if (np_dsc[j] == DSC_ROW) begin
                    np_dup[j] = (p_row[np_ptr[j]] == in_row) && (AW'(in_col) == np_addr[j])
                                && (p_bnk[np_ptr[j]] == in_bnk);
                end else begin
                    np_dup[j] = (AW'(in_row) == np_addr[j]) && (p_col[np_ptr[j]] == in_col)
                                && (p_bnk[np_ptr[j]] == in_bnk);
                end
            end
        end
    end

    always_comb begin
        row_idx = '0;
        col_idx = '0;
        for (int i = PCAM_N - 1; i >= 0; i--) begin
            if (row_m[i]) row_idx = IDX_W'(i);
            if (col_m[i]) col_idx = IDX_W'(i);
        end
    end

    assign hit_row = |row_m;
    assign hit_col = !hit_row && (|col_m);
    assign hit_idx = hit_row ? row_idx : col_idx;
    assign dup     = (|p_dup) || (|np_dup);

endmodule

// File: rtl/fault_cam_ra.sv
// Fault-collection CAM for built-in redundancy analysis: pivot / non-pivot classification,
// must-repair tracking and early unrepairable detection. Optional macro: FAULT_CAM_COL_GROUP_EN.
module fault_cam_ra
    import fault_cam_pkg::*;
#(
    parameter int ROW_W   = 10,
    parameter int COL_W   = 10,
    parameter int BNK_W   = 2,
    parameter int SPARE_R = 2,
    parameter int SPARE_C = 2,
    parameter int PCAM_N  = 8,
    parameter int NPCAM_N = 30,
    localparam int IDX_W  = (PCAM_N > 1) ? $clog2(PCAM_N) : 1,
    localparam int NIW    = (NPCAM_N > 1) ? $clog2(NPCAM_N) : 1,
    localparam int AW     = (ROW_W > COL_W) ? ROW_W : COL_W,
    localparam int PCW    = $clog2(PCAM_N + 1),
    localparam int NCW    = $clog2(NPCAM_N + 1)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           clear,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [ROW_W-1:0]               in_row,
    input  logic [COL_W-1:0]               in_col,
    input  logic [BNK_W-1:0]               in_bnk,
`ifdef FAULT_CAM_COL_GROUP_EN
    input  logic [7:0]                     col_flag,
`endif
    input  logic                           test_end,
    output logic [1:0]                     state,
    output logic                           unrepairable,
    output logic [PCW-1:0]                 pcam_cnt,
    output logic [NCW-1:0]                 npcam_cnt,
    input  logic [IDX_W-1:0]               p_rd_idx,
    output logic [ROW_W+COL_W+BNK_W+2:0]   p_rd_entry,
    input  logic [NIW-1:0]                 np_rd_idx,
    output logic [1+IDX_W+AW:0]            np_rd_entry
);

    localparam int RCW = $clog2(SPARE_C + 2);
    localparam int CCW = $clog2(SPARE_R + 2);
    localparam logic [RCW-1:0] ROW_LIM = RCW'(SPARE_C);
    localparam logic [CCW-1:0] COL_LIM = CCW'(SPARE_R);

    typedef struct packed {
        logic             valid;
        logic [ROW_W-1:0] row;
        logic [COL_W-1:0] col;
        logic [BNK_W-1:0] bnk;
        logic             must_row;
        logic             must_col;
    } pivot_t;

    typedef struct packed {
        logic             valid;
        logic             dscrpt;
        logic [IDX_W-1:0] ptr;
        logic [AW-1:0]    addr;
    } npiv_t;

    pivot_t         piv     [PCAM_N];
    npiv_t          np      [NPCAM_N];
    logic [RCW-1:0] row_cnt [PCAM_N];
    logic [CCW-1:0] col_cnt [PCAM_N];
    logic [1:0]     state_q;
    logic [1:0]     state_d;
    logic [PCW-1:0] p_cnt;
    logic [NCW-1:0] np_cnt;

    logic [COL_W-1:0] eff_col;
`ifdef FAULT_CAM_COL_GROUP_EN
    assign eff_col = in_col | COL_W'(msb_idx8(col_flag));
`else
    assign eff_col = in_col;
`endif

    logic [PCAM_N-1:0]             p_valid_f;
    logic [PCAM_N-1:0][ROW_W-1:0]  p_row_f;
    logic [PCAM_N-1:0][COL_W-1:0]  p_col_f;
    logic [PCAM_N-1:0][BNK_W-1:0]  p_bnk_f;
    logic [NPCAM_N-1:0]            np_valid_f;
    logic [NPCAM_N-1:0]            np_dsc_f;
    logic [NPCAM_N-1:0][IDX_W-1:0] np_ptr_f;
    logic [NPCAM_N-1:0][AW-1:0]    np_addr_f;

    always_comb begin
        for (int i = 0; i < PCAM_N; i++) begin
            p_valid_f[i] = piv[i].valid;
            p_row_f[i]   = piv[i].row;
            p_col_f[i]   = piv[i].col;
            p_bnk_f[i]   = piv[i].bnk;
        end
        for (int j = 0; j < NPCAM_N; j++) begin
            np_valid_f[j] = np[j].valid;
            np_dsc_f[j]   = np[j].dscrpt;
            np_ptr_f[j]   = np[j].ptr;
            np_addr_f[j]  = np[j].addr;
        end
    end

    logic             hit_row;
    logic             hit_col;
    logic [IDX_W-1:0] hit_idx;
    logic             dup;

    fault_cam_match #(
        .ROW_W(ROW_W), .COL_W(COL_W), .BNK_W(BNK_W), .PCAM_N(PCAM_N),
        .NPCAM_N(NPCAM_N), .IDX_W(IDX_W), .AW(AW)
    ) u_match (
        .in_row(in_row), .in_col(eff_col), .in_bnk(in_bnk),
        .p_valid(p_valid_f), .p_row(p_row_f), .p_col(p_col_f), .p_bnk(p_bnk_f),
        .np_valid(np_valid_f), .np_dsc(np_dsc_f), .np_ptr(np_ptr_f), .np_addr(np_addr_f),
        .hit_row(hit_row), .hit_col(hit_col), .hit_idx(hit_idx), .dup(dup)
    );

    // Valid/ready: a fault transfers on a rising edge where in_valid && in_ready; in_ready
    // depends only on the registered state, and in_valid must hold its address while waiting.
    logic accept;
    assign accept = in_valid && in_ready && !clear;

    logic           do_alloc, do_np, np_dsc, set_mr, set_mc, inc_r, inc_c, ovf, go_fail;
    logic [AW-1:0]  np_addr;
    logic [RCW-1:0] hrc;
    logic [CCW-1:0] hcc;
    int             mr_n;
    int             mc_n;

    assign hrc = row_cnt[hit_idx];
    assign hcc = col_cnt[hit_idx];

    always_comb begin
        do_alloc = 1'b0;
        do_np    = 1'b0;
        np_dsc   = DSC_ROW;
        np_addr  = '0;
        set_mr   = 1'b0;
        set_mc   = 1'b0;
        inc_r    = 1'b0;
        inc_c    = 1'b0;
        ovf      = 1'b0;
        if (accept && !dup) begin
            if (hit_row) begin
                if (!piv[hit_idx].must_row) begin
                    if (hrc == ROW_LIM) set_mr = 1'b1;
                    else if (32'(np_cnt) == NPCAM_N) ovf = 1'b1;
                    else begin
                        do_np   = 1'b1;
                        np_dsc  = DSC_ROW;
                        np_addr = AW'(eff_col);
                        inc_r   = 1'b1;
                    end
                end
            end else if (hit_col) begin
                if (!piv[hit_idx].must_col) begin
                    if (hcc == COL_LIM) set_mc = 1'b1;
                    else if (32'(np_cnt) == NPCAM_N) ovf = 1'b1;
                    else begin
                        do_np   = 1'b1;
                        np_dsc  = DSC_COL;
                        np_addr = AW'(in_row);
                        inc_c   = 1'b1;
                    end
                end
            end else if (32'(p_cnt) == PCAM_N) begin
                ovf = 1'b1;
            end else begin
                do_alloc = 1'b1;
            end
        end
    end

    // Must-repair lines already committed in the fault's bank; the new one must still fit.
    always_comb begin
        mr_n = 0;
        mc_n = 0;
        for (int i = 0; i < PCAM_N; i++) begin
            if (piv[i].valid && (piv[i].bnk == in_bnk)) begin
                if (piv[i].must_row) mr_n = mr_n + 1;
                if (piv[i].must_col) mc_n = mc_n + 1;
            end
        end
    end

    assign go_fail = ovf || (set_mr && (mr_n >= SPARE_R)) || (set_mc && (mc_n >= SPARE_C));

    always_comb begin
        state_d = state_q;
        if (clear) begin
            state_d = ST_COLLECT;
        end else if (state_q == ST_COLLECT) begin
            if (go_fail) state_d = ST_FAIL;
            else if (test_end) state_d = ST_DONE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_COLLECT;
            p_cnt   <= '0;
            np_cnt  <= '0;
            for (int i = 0; i < PCAM_N; i++) begin
                piv[i]     <= '0;
                row_cnt[i] <= '0;
                col_cnt[i] <= '0;
            end
            for (int j = 0; j < NPCAM_N; j++) np[j] <= '0;
        end else begin
            state_q <= state_d;
            if (clear) begin
                p_cnt  <= '0;
                np_cnt <= '0;
                for (int i = 0; i < PCAM_N; i++) begin
                    piv[i]     <= '0;
                    row_cnt[i] <= '0;
                    col_cnt[i] <= '0;
                end
                for (int j = 0; j < NPCAM_N; j++) np[j] <= '0;
            end else if (!go_fail) begin
                if (do_alloc) begin
                    piv[IDX_W'(p_cnt)]     <= '{valid: 1'b1, row: in_row, col: eff_col, bnk: in_bnk,
                                                must_row: 1'b0, must_col: 1'b0};
                    row_cnt[IDX_W'(p_cnt)] <= RCW'(1);
                    col_cnt[IDX_W'(p_cnt)] <= CCW'(1);
                    p_cnt                  <= p_cnt + 1'b1;
                end
                if (do_np) begin
                    np[NIW'(np_cnt)] <= '{valid: 1'b1, dscrpt: np_dsc, ptr: hit_idx, addr: np_addr};
                    np_cnt           <= np_cnt + 1'b1;
                end
                if (inc_r && (hrc != '1)) row_cnt[hit_idx] <= hrc + 1'b1;
                if (inc_c && (hcc != '1)) col_cnt[hit_idx] <= hcc + 1'b1;
                if (set_mr) piv[hit_idx].must_row <= 1'b1;
                if (set_mc) piv[hit_idx].must_col <= 1'b1;
            end
        end
    end

    assign state        = state_q;
    assign in_ready     = (state_q == ST_COLLECT);
    assign unrepairable = (state_q == ST_FAIL);
    assign pcam_cnt     = p_cnt;
    assign npcam_cnt    = np_cnt;
    assign p_rd_entry   = (32'(p_rd_idx) < PCAM_N) ? piv[p_rd_idx] : '0;
    assign np_rd_entry  = (32'(np_rd_idx) < NPCAM_N) ? np[np_rd_idx] : '0;

endmodule

// File: tb/tb_fault_cam_ra.sv
// Directed bench for fault_cam_ra: a default-size instance and a PCAM_N=4 instance
// share the clock, reset and address bus but have their own control inputs.
module tb_fault_cam_ra;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [9:0] in_row = '0;
    logic [9:0] in_col = '0;
    logic [1:0] in_bnk = '0;

    // default instance
    logic        vd = 1'b0, clrd = 1'b0, ted = 1'b0;
    logic        rdy_d, unr_d;
    logic [1:0]  st_d;
    logic [3:0]  pc_d;
    logic [4:0]  npc_d;
    logic [2:0]  pidx_d = '0;
    logic [24:0] pent_d;
    logic [4:0]  npidx_d = '0;
    logic [14:0] npent_d;

    // PCAM_N = 4 instance
    logic        v4 = 1'b0, clr4 = 1'b0;
    logic        rdy_4, unr_4;
    logic [1:0]  st_4;
    logic [2:0]  pc_4;
    logic [4:0]  npc_4;
    logic [1:0]  pidx_4 = '0;
    logic [24:0] pent_4;
    logic [4:0]  npidx_4 = '0;
    logic [13:0] npent_4;

    fault_cam_ra dut (
        .clk(clk), .rst(rst), .clear(clrd), .in_valid(vd), .in_ready(rdy_d),
        .in_row(in_row), .in_col(in_col), .in_bnk(in_bnk), .test_end(ted),
        .state(st_d), .unrepairable(unr_d), .pcam_cnt(pc_d), .npcam_cnt(npc_d),
        .p_rd_idx(pidx_d), .p_rd_entry(pent_d), .np_rd_idx(npidx_d), .np_rd_entry(npent_d)
    );

    fault_cam_ra #(.PCAM_N(4)) dut4 (
        .clk(clk), .rst(rst), .clear(clr4), .in_valid(v4), .in_ready(rdy_4),
        .in_row(in_row), .in_col(in_col), .in_bnk(in_bnk), .test_end(1'b0),
        .state(st_4), .unrepairable(unr_4), .pcam_cnt(pc_4), .npcam_cnt(npc_4),
        .p_rd_idx(pidx_4), .p_rd_entry(pent_4), .np_rd_idx(npidx_4), .np_rd_entry(npent_4)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns one cycle later with the result registered.
    task automatic send(input bit four, input logic [9:0] r, input logic [9:0] c,
                        input logic [1:0] b, input bit te);
        in_row = r;
        in_col = c;
        in_bnk = b;
        if (four) v4 = 1'b1;
        else begin
            vd  = 1'b1;
            ted = te;
        end
        @(negedge clk);
        v4  = 1'b0;
        vd  = 1'b0;
        ted = 1'b0;
    endtask

    task automatic pulse_clear(input bit four);
        if (four) clr4 = 1'b1;
        else clrd = 1'b1;
        @(negedge clk);
        clr4 = 1'b0;
        clrd = 1'b0;
    endtask

    function automatic logic [24:0] pent(input logic [9:0] r, input logic [9:0] c,
                                         input logic [1:0] b, input logic mr, input logic mc);
        return {1'b1, r, c, b, mr, mc};
    endfunction

    initial begin
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // reset state
        check("rst_pcnt", 32'(pc_d), 0);
        check("rst_npcnt", 32'(npc_d), 0);
        check("rst_unrep", 32'(unr_d), 0);
        check("rst_ready", 32'(rdy_d), 1);
        check("rst_state", 32'(st_d), 0);
        check("rst_pent", 32'(pent_d), 0);

        // new pivot, then exact duplicate
        send(0, 10'd5, 10'd7, 2'd0, 0);
        send(0, 10'd5, 10'd7, 2'd0, 0);
        pidx_d = 3'd0;
        #1;
        check("dup_pcnt", 32'(pc_d), 1);
        check("dup_npcnt", 32'(npc_d), 0);
        check("piv0", 32'(pent_d), 32'(pent(10'd5, 10'd7, 2'd0, 1'b0, 1'b0)));

        // row matches: one non-pivot, then must_row
        send(0, 10'd5, 10'd9, 2'd0, 0);
        send(0, 10'd5, 10'd11, 2'd0, 0);
        npidx_d = 5'd0;
        #1;
        check("np0", 32'(npent_d), 32'({1'b1, 1'b0, 3'd0, 10'd9}));
        check("piv0_mr", 32'(pent_d), 32'(pent(10'd5, 10'd7, 2'd0, 1'b1, 1'b0)));
        check("mr_npcnt", 32'(npc_d), 1);

        // duplicate of a non-pivot, then absorbed by must_row
        send(0, 10'd5, 10'd9, 2'd0, 0);
        send(0, 10'd5, 10'd13, 2'd0, 0);
        check("absorb_npcnt", 32'(npc_d), 1);

        // column match: non-pivot with dscrpt=1, addr=row; its duplicate is dropped
        send(0, 10'd8, 10'd7, 2'd0, 0);
        npidx_d = 5'd1;
        #1;
        check("np1_col", 32'(npent_d), 32'({1'b1, 1'b1, 3'd0, 10'd8}));
        send(0, 10'd8, 10'd7, 2'd0, 0);
        check("coldup_npcnt", 32'(npc_d), 2);

        // same row/col in another bank is a new pivot
        send(0, 10'd5, 10'd7, 2'd1, 0);
        pidx_d = 3'd1;
        #1;
        check("bank_pcnt", 32'(pc_d), 2);
        check("piv1", 32'(pent_d), 32'(pent(10'd5, 10'd7, 2'd1, 1'b0, 1'b0)));

        // out-of-range non-pivot index reads zero
        npidx_d = 5'd31;
        #1;
        check("np_oor", 32'(npent_d), 0);

        // test_end with a fault: stored, then DONE ignores inputs
        send(0, 10'd3, 10'd3, 2'd1, 1);
        check("te_state", 32'(st_d), 2);
        check("te_pcnt", 32'(pc_d), 3);
        check("te_ready", 32'(rdy_d), 0);
        send(0, 10'd9, 10'd9, 2'd0, 0);
        pidx_d = 3'd2;
        #1;
        check("done_pcnt", 32'(pc_d), 3);
        check("piv2", 32'(pent_d), 32'(pent(10'd3, 10'd3, 2'd1, 1'b0, 1'b0)));
        pulse_clear(0);
        check("clr_d_state", 32'(st_d), 0);
        check("clr_d_pcnt", 32'(pc_d), 0);

        // PCAM_N=4: fifth distinct pivot overflows
        send(1, 10'd1, 10'd1, 2'd0, 0);
        send(1, 10'd2, 10'd2, 2'd0, 0);
        send(1, 10'd3, 10'd3, 2'd0, 0);
        send(1, 10'd4, 10'd4, 2'd0, 0);
        check("full_state", 32'(st_4), 0);
        check("full_pcnt", 32'(pc_4), 4);
        send(1, 10'd6, 10'd6, 2'd0, 0);
        check("ovf_state", 32'(st_4), 1);
        check("ovf_unrep", 32'(unr_4), 1);
        check("ovf_ready", 32'(rdy_4), 0);
        check("ovf_pcnt", 32'(pc_4), 4);
        pulse_clear(1);
        check("clr4_state", 32'(st_4), 0);

        // three pivots, then a third must_row in bank 0 exceeds SPARE_R=2
        send(1, 10'd1, 10'd1, 2'd0, 0);
        send(1, 10'd2, 10'd2, 2'd0, 0);
        send(1, 10'd3, 10'd3, 2'd0, 0);
        send(1, 10'd1, 10'd10, 2'd0, 0);
        send(1, 10'd1, 10'd11, 2'd0, 0);
        send(1, 10'd2, 10'd12, 2'd0, 0);
        send(1, 10'd2, 10'd13, 2'd0, 0);
        check("mr2_state", 32'(st_4), 0);
        send(1, 10'd3, 10'd14, 2'd0, 0);
        send(1, 10'd3, 10'd15, 2'd0, 0);
        check("mr3_state", 32'(st_4), 1);
        check("mr3_unrep", 32'(unr_4), 1);
        check("mr3_pcnt", 32'(pc_4), 3);
        check("mr3_npcnt", 32'(npc_4), 3);

        // clear in FAIL with three pivots stored
        pulse_clear(1);
        pidx_4 = 2'd0;
        #1;
        check("clr_state", 32'(st_4), 0);
        check("clr_pcnt", 32'(pc_4), 0);
        check("clr_npcnt", 32'(npc_4), 0);
        check("clr_pent", 32'(pent_4), 0);
        check("clr_ready", 32'(rdy_4), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
